stage_mem: RTL and testbench
============================

STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 The block SHALL use clock clk and reset rst, where rst is synchronous and active-high.
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- PC_I  in  32  PC of the instruction in EX/MEM
- Done_I  in  1  EX/MEM slot holds a valid instruction
- MCR_I  in  6  {MemW, MemR, Write_strb[3:0]}
- WDR_I  in  32  store data, already lane-shifted
- ASR_I  in  32  ALU/shift result, or memory byte address
- RAR_I  in  5  regfile write address
- F3R_I  in  3  funct3
- Address  out  32  word-aligned memory address
- MemWrite  out  1  write request
- Write_data  out  32  store data
- Write_strb  out  4  byte enables
- MemRead  out  1  read request
- Mem_Req_Ready  in  1  memory accepts the request
- Read_data  in  32  load data
- Read_data_Valid  in  1  load data valid
- Read_data_Ready  out  1  block can accept load data
- Feedback_Mem_Acc  out  1  stall request to the upstream stage, which holds while this is high
- PC_O  out  32  PC to WB
- Done_O  out  1  valid instruction to WB
- RF_waddr_O  out  5  writeback address
- RF_wdata_O  out  32  writeback data

Function
REQ-003 The FSM SHALL have states IDLE, REQ and RDW; memop = Done_I & (MemW | MemR).
REQ-004 In IDLE: memop -> REQ; otherwise stay in IDLE.
REQ-005 In REQ the block SHALL drive MemWrite = MemW, MemRead = MemR, Address = {ASR_I[31:2],2'b00}, Write_data = WDR_I and Write_strb = MCR_I[3:0].
REQ-006 In REQ with Mem_Req_Ready: if MemW -> IDLE (store completes); if MemR -> RDW; otherwise stay in REQ.
REQ-007 In RDW the block SHALL assert Read_data_Ready = 1; Read_data_Valid -> IDLE (load completes).
REQ-008 MemWrite, MemRead and Read_data_Ready SHALL be 0 in every other state and whenever rst = 1.
REQ-009 Feedback_Mem_Acc SHALL equal (IDLE & memop) | (REQ & ~(Mem_Req_Ready & MemW)) | (RDW & ~Read_data_Valid), forced to 0 while rst = 1.
REQ-010 Feedback_Mem_Acc SHALL be low in the completion cycle, so the upstream stage advances on the same edge that this block captures the result.
REQ-011 Registered outputs SHALL update per case:
- IDLE & ~memop: Done_O <= Done_I.
- Completion edge: Done_O <= 1.
- Every other edge: Done_O <= 0.
- PC_O, RF_waddr_O and RF_wdata_O SHALL load whenever Done_O loads 1.
REQ-012 RF_waddr_O SHALL be 0 for stores and RAR_I otherwise.
REQ-013 RF_wdata_O SHALL be ASR_I for non-loads. For loads, with byte offset o = ASR_I[1:0]:
- LB (000): sign-extend byte o.
- LBU (100): zero-extend byte o.
- LH (001): sign-extend halfword o[1].
- LHU (101): zero-extend halfword o[1].
- LW (010): whole word.
REQ-014 Memory latency SHALL be unbounded: the block SHALL stall indefinitely in REQ or RDW without corrupting any held output.
REQ-015 A non-memory instruction SHALL pass through with 1-cycle latency and no stall.
REQ-016 A store SHALL take at least 2 cycles and a load at least 3 cycles.
REQ-017 Read_data_Valid arriving outside RDW SHALL be ignored.

Reset
REQ-018 On a rst edge the block SHALL set state = IDLE, Done_O = 0, RF_waddr_O = 0, RF_wdata_O = 0 and PC_O = 0, including when a transaction is in flight (mid-operation).
REQ-019 The block SHALL drop any in-flight transaction with no retry after reset.

Configuration
REQ-020 With MEM_PERF_CNT_EN defined, the block SHALL add output Mem_stall_cycles[31:0] with this behaviour:
- It increments on every edge where Feedback_Mem_Acc = 1.
- It resets to 0.
- It wraps from 0xFFFFFFFF to 0.
REQ-021 Without MEM_PERF_CNT_EN the Mem_stall_cycles port and its counter SHALL be absent, with no other change in behaviour.

Verification
REQ-022 Non-memory instruction: Done_I = 1, MCR_I = 0, ASR_I = 0x1234, RAR_I = 5 -> next cycle Done_O = 1, RF_wdata_O = 0x1234, RF_waddr_O = 5, Feedback_Mem_Acc = 0 throughout.
REQ-023 Store: SW to ASR_I = 0x100, strb = 0xF, Mem_Req_Ready delayed 3 cycles -> Feedback_Mem_Acc high 4 cycles, MemWrite held stable with Address = 0x100, Done_O = 1 one cycle later, RF_waddr_O = 0.
REQ-024 Load: LB at ASR_I = 0x103, Read_data = 0x80000000, Valid 2 cycles after accept -> RF_wdata_O = 0xFFFFFF80.
REQ-025 Load variants at ASR_I = 0x102 with Read_data = 0x80000000:
- LHU -> RF_wdata_O = 0x00008000.
- LH -> RF_wdata_O = 0xFFFF8000.
- LW at 0x100 -> RF_wdata_O = 0x80000000.
REQ-026 rst asserted while in RDW -> next cycle IDLE, Done_O = 0, Read_data_Ready = 0, and a late Read_data_Valid is ignored.
REQ-027 With MEM_PERF_CNT_EN defined: 10 stall cycles -> Mem_stall_cycles = 10; after reset -> Mem_stall_cycles = 0.

Source files
------------

// File: rtl/stage_mem.sv
// stage_mem: memory-access pipeline stage between EX/MEM and WB.
// Issues one load or store per valid memory instruction and holds the upstream
// stage through Feedback_Mem_Acc until the access completes. Memory latency is
// unbounded in both the request and read-data phases.
// Optional build macro MEM_PERF_CNT_EN adds a Mem_stall_cycles output that
// counts every cycle the upstream stage is stalled.
module stage_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_I,
    input  logic        Done_I,
    input  logic [5:0]  MCR_I,
    input  logic [31:0] WDR_I,
    input  logic [31:0] ASR_I,
    input  logic [4:0]  RAR_I,
    input  logic [2:0]  F3R_I,
    output logic [31:0] Address,
    output logic        MemWrite,
    output logic [31:0] Write_data,
    output logic [3:0]  Write_strb,
    output logic        MemRead,
    input  logic        Mem_Req_Ready,
    input  logic [31:0] Read_data,
    input  logic        Read_data_Valid,
    output logic        Read_data_Ready,
    output logic        Feedback_Mem_Acc,
`ifdef MEM_PERF_CNT_EN
    output logic [31:0] Mem_stall_cycles,
`endif
    output logic [31:0] PC_O,
    output logic        Done_O,
    output logic [4:0]  RF_waddr_O,
    output logic [31:0] RF_wdata_O
);

    typedef enum logic [1:0] {IDLE, REQ, RDW} state_t;

    state_t      r_state;
    state_t      w_state_d;
    logic        r_done;
    logic [31:0] r_pc;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;

    logic        w_memw;
    logic        w_memr;
    logic        w_memop;
    logic        w_complete;
    logic        w_pass;
    logic        w_load_wb;
    logic [31:0] w_byte_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_wdata_d;
    logic [4:0]  w_waddr_d;

    assign w_memw  = MCR_I[5];
    assign w_memr  = MCR_I[4];
    assign w_memop = Done_I & (w_memw | w_memr);

    // Completion: store accepted, or load data returned while waiting for it.
    assign w_complete = ((r_state == REQ) & Mem_Req_Ready & w_memw) |
                        ((r_state == RDW) & Read_data_Valid);
    // Non-memory slot passing straight through from IDLE.
    assign w_pass     = (r_state == IDLE) & ~w_memop;
    // Writeback fields load whenever Done_O is about to load 1.
    assign w_load_wb  = w_complete | (w_pass & Done_I);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state logic; upstream inputs are held stable while stalled.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE: if (w_memop) w_state_d = REQ;
            REQ: begin
                if (Mem_Req_Ready) begin
                    if (w_memw)      w_state_d = IDLE;
                    else if (w_memr) w_state_d = RDW;
                end
            end
            RDW: if (Read_data_Valid) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // Memory-side outputs and stall request; all handshakes quiet during reset.
    always_comb begin
        MemWrite         = 1'b0;
        MemRead          = 1'b0;
        Read_data_Ready  = 1'b0;
        Address          = 32'h0;
        Write_data       = 32'h0;
        Write_strb       = 4'h0;
        Feedback_Mem_Acc = 1'b0;
        if (!rst) begin
            unique case (r_state)
                IDLE: Feedback_Mem_Acc = w_memop;
                REQ: begin
                    MemWrite         = w_memw;
                    MemRead          = w_memr;
                    Address          = {ASR_I[31:2], 2'b00};
                    Write_data       = WDR_I;
                    Write_strb       = MCR_I[3:0];
                    Feedback_Mem_Acc = ~(Mem_Req_Ready & w_memw);
                end
                RDW: begin
                    Read_data_Ready  = 1'b1;
                    Feedback_Mem_Acc = ~Read_data_Valid;
                end
                default: ;
            endcase
        end
    end

    // Load lane extraction by byte offset and funct3.
    always_comb begin
        w_byte_shift = Read_data >> {ASR_I[1:0], 3'b000};
        w_byte       = w_byte_shift[7:0];
        w_half       = ASR_I[1] ? Read_data[31:16] : Read_data[15:0];
        unique case (F3R_I)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = Read_data;
        endcase
    end

    // Writeback data selection: loads complete only from RDW.
    always_comb begin
        w_wdata_d = (r_state == RDW) ? w_load_data : ASR_I;
        w_waddr_d = w_memw ? 5'd0 : RAR_I;
    end

    // WB-facing registers; a reset drops any in-flight access outright.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done  <= 1'b0;
            r_pc    <= 32'h0;
            r_waddr <= 5'd0;
            r_wdata <= 32'h0;
        end else begin
            r_done <= w_complete | (w_pass & Done_I);
            if (w_load_wb) begin
                r_pc    <= PC_I;
                r_waddr <= w_waddr_d;
                r_wdata <= w_wdata_d;
            end
        end
    end

    assign Done_O     = r_done;
    assign PC_O       = r_pc;
    assign RF_waddr_O = r_waddr;
    assign RF_wdata_O = r_wdata;

`ifdef MEM_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    // Stall-cycle counter; wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'h0;
        end else if (Feedback_Mem_Acc) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign Mem_stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_stage_mem.sv
// Directed testbench for stage_mem. Inputs change 1 ns after each rising edge;
// outputs are checked before the next edge.
module tb_stage_mem;

    logic        clk;
    logic        rst;
    logic [31:0] PC_I;
    logic        Done_I;
    logic [5:0]  MCR_I;
    logic [31:0] WDR_I;
    logic [31:0] ASR_I;
    logic [4:0]  RAR_I;
    logic [2:0]  F3R_I;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;
    logic        Feedback_Mem_Acc;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] Mem_stall_cycles;
`endif
    logic [31:0] PC_O;
    logic        Done_O;
    logic [4:0]  RF_waddr_O;
    logic [31:0] RF_wdata_O;

    int n_vec;
    int n_err;

    stage_mem dut (
        .clk              (clk),
        .rst              (rst),
        .PC_I             (PC_I),
        .Done_I           (Done_I),
        .MCR_I            (MCR_I),
        .WDR_I            (WDR_I),
        .ASR_I            (ASR_I),
        .RAR_I            (RAR_I),
        .F3R_I            (F3R_I),
        .Address          (Address),
        .MemWrite         (MemWrite),
        .Write_data       (Write_data),
        .Write_strb       (Write_strb),
        .MemRead          (MemRead),
        .Mem_Req_Ready    (Mem_Req_Ready),
        .Read_data        (Read_data),
        .Read_data_Valid  (Read_data_Valid),
        .Read_data_Ready  (Read_data_Ready),
        .Feedback_Mem_Acc (Feedback_Mem_Acc),
`ifdef MEM_PERF_CNT_EN
        .Mem_stall_cycles (Mem_stall_cycles),
`endif
        .PC_O             (PC_O),
        .Done_O           (Done_O),
        .RF_waddr_O       (RF_waddr_O),
        .RF_wdata_O       (RF_wdata_O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Done_I          = 1'b0;
        MCR_I           = 6'h0;
        PC_I            = 32'h0;
        WDR_I           = 32'h0;
        ASR_I           = 32'h0;
        RAR_I           = 5'd0;
        F3R_I           = 3'd0;
        Mem_Req_Ready   = 1'b0;
        Read_data       = 32'h0;
        Read_data_Valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        // Present a memop while reset is held: handshakes must stay quiet.
        Done_I = 1'b1; MCR_I = 6'b01_0000; Mem_Req_Ready = 1'b1;
        #1;
        n_vec++;
        if (Feedback_Mem_Acc !== 1'b0 || MemRead !== 1'b0 || MemWrite !== 1'b0) begin
            n_err++;
            $display("FAIL reset_quiet: fb=%b rd=%b wr=%b, want 0 0 0",
                     Feedback_Mem_Acc, MemRead, MemWrite);
        end
        tick();
        n_vec++;
        if (Done_O !== 1'b0 || PC_O !== 32'h0 || RF_waddr_O !== 5'd0 || RF_wdata_O !== 32'h0) begin
            n_err++;
            $display("FAIL reset_regs: done=%b pc=%h wa=%0d wd=%h, want 0 0 0 0",
                     Done_O, PC_O, RF_waddr_O, RF_wdata_O);
        end
`ifdef MEM_PERF_CNT_EN
        n_vec++;
        if (Mem_stall_cycles !== 32'h0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d want 0", Mem_stall_cycles);
        end
`endif
        idle_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_nonmem();
        Done_I = 1'b1; MCR_I = 6'h0; ASR_I = 32'h1234; RAR_I = 5'd5; PC_I = 32'h40;
        #1;
        n_vec++;
        if (Feedback_Mem_Acc !== 1'b0 || MemWrite !== 1'b0 || MemRead !== 1'b0) begin
            n_err++;
            $display("FAIL nonmem_nostall: fb=%b wr=%b rd=%b, want 0 0 0",
                     Feedback_Mem_Acc, MemWrite, MemRead);
        end
        tick();
        n_vec++;
        if (Done_O !== 1'b1 || RF_wdata_O !== 32'h1234 || RF_waddr_O !== 5'd5 ||
            PC_O !== 32'h40) begin
            n_err++;
            $display("FAIL nonmem_wb: done=%b wd=%h wa=%0d pc=%h, want 1 1234 5 40",
                     Done_O, RF_wdata_O, RF_waddr_O, PC_O);
        end
        idle_inputs();
        tick();
        n_vec++;
        if (Done_O !== 1'b0 || RF_wdata_O !== 32'h1234) begin
            n_err++;
            $display("FAIL nonmem_bubble: done=%b wd=%h, want 0 1234", Done_O, RF_wdata_O);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            Done_I = 1'b1; MCR_I = 6'h0; ASR_I = 32'(i * 17); RAR_I = 5'(i);
            PC_I = 32'(i * 4);
            tick();
            n_vec++;
            if (Done_O !== 1'b1 || RF_wdata_O !== 32'(i * 17) || RF_waddr_O !== 5'(i) ||
                Feedback_Mem_Acc !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_%0d: done=%b wd=%h wa=%0d fb=%b, want 1 %h %0d 0", i,
                         Done_O, RF_wdata_O, RF_waddr_O, Feedback_Mem_Acc, 32'(i * 17), i);
            end
        end
        idle_inputs();
        tick();
    endtask

    // Store with n_wait not-ready REQ cycles; stalls for n_wait+1 cycles in total.
    task automatic run_store(input int n_wait);
        int fb_cnt;
        fb_cnt = 0;
        Done_I = 1'b1; MCR_I = 6'b10_1111; ASR_I = 32'h100; WDR_I = 32'hDEADBEEF;
        RAR_I = 5'd7; F3R_I = 3'b010; PC_I = 32'h80; Mem_Req_Ready = 1'b0;
        #1;
        if (Feedback_Mem_Acc === 1'b1) fb_cnt++;
        for (int i = 0; i < n_wait; i++) begin
            tick();
            n_vec++;
            if (MemWrite !== 1'b1 || Address !== 32'h100 || Write_data !== 32'hDEADBEEF ||
                Write_strb !== 4'hF || MemRead !== 1'b0 || Done_O !== 1'b0) begin
                n_err++;
                $display("FAIL store_hold_%0d: wr=%b a=%h d=%h s=%h rd=%b done=%b", i,
                         MemWrite, Address, Write_data, Write_strb, MemRead, Done_O);
            end
            if (Feedback_Mem_Acc === 1'b1) fb_cnt++;
        end
        tick();
        Mem_Req_Ready = 1'b1;
        #1;
        if (Feedback_Mem_Acc === 1'b1) fb_cnt++;
        n_vec++;
        if (MemWrite !== 1'b1 || Feedback_Mem_Acc !== 1'b0) begin
            n_err++;
            $display("FAIL store_accept: wr=%b fb=%b, want 1 0", MemWrite, Feedback_Mem_Acc);
        end
        n_vec++;
        if (fb_cnt != n_wait + 1) begin
            n_err++;
            $display("FAIL store_stall_len: got %0d want %0d", fb_cnt, n_wait + 1);
        end
        tick();
        n_vec++;
        if (Done_O !== 1'b1 || RF_waddr_O !== 5'd0 || RF_wdata_O !== 32'h100 ||
            PC_O !== 32'h80) begin
            n_err++;
            $display("FAIL store_wb: done=%b wa=%0d wd=%h pc=%h, want 1 0 100 80",
                     Done_O, RF_waddr_O, RF_wdata_O, PC_O);
        end
        idle_inputs();
        #1;
        n_vec++;
        if (MemWrite !== 1'b0 || Feedback_Mem_Acc !== 1'b0) begin
            n_err++;
            $display("FAIL store_idle: wr=%b fb=%b, want 0 0", MemWrite, Feedback_Mem_Acc);
        end
        tick();
    endtask

    task automatic test_store();
        run_store(3);
    endtask

    // Load accepted on the first REQ cycle; valid arrives lat cycles after accept.
    task automatic run_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] expv, input int lat);
        Done_I = 1'b1; MCR_I = 6'b01_0000; ASR_I = addr; RAR_I = 5'd9; F3R_I = f3;
        PC_I = 32'hC0; Mem_Req_Ready = 1'b1;
        #1;
        n_vec++;
        if (Feedback_Mem_Acc !== 1'b1 || MemRead !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: fb=%b rd=%b, want 1 0", name, Feedback_Mem_Acc, MemRead);
        end
        tick();
        n_vec++;
        if (MemRead !== 1'b1 || Address !== {addr[31:2], 2'b00} || Feedback_Mem_Acc !== 1'b1 ||
            MemWrite !== 1'b0) begin
            n_err++;
            $display("FAIL %s_req: rd=%b a=%h fb=%b wr=%b, want 1 %h 1 0", name, MemRead,
                     Address, Feedback_Mem_Acc, MemWrite, {addr[31:2], 2'b00});
        end
        tick();
        Mem_Req_Ready = 1'b0;
        for (int i = 1; i < lat; i++) begin
            #1;
            n_vec++;
            if (Read_data_Ready !== 1'b1 || Feedback_Mem_Acc !== 1'b1 || MemRead !== 1'b0 ||
                Done_O !== 1'b0) begin
                n_err++;
                $display("FAIL %s_rdw: rdy=%b fb=%b rd=%b done=%b, want 1 1 0 0", name,
                         Read_data_Ready, Feedback_Mem_Acc, MemRead, Done_O);
            end
            tick();
        end
        Read_data = rdata; Read_data_Valid = 1'b1;
        #1;
        n_vec++;
        if (Feedback_Mem_Acc !== 1'b0 || Read_data_Ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_done_fb: fb=%b rdy=%b, want 0 1", name, Feedback_Mem_Acc,
                     Read_data_Ready);
        end
        tick();
        n_vec++;
        if (Done_O !== 1'b1 || RF_wdata_O !== expv || RF_waddr_O !== 5'd9) begin
            n_err++;
            $display("FAIL %s_wb: done=%b wd=%h wa=%0d, want 1 %h 9", name, Done_O,
                     RF_wdata_O, RF_waddr_O, expv);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_loads();
        run_load("lb",  3'b000, 32'h103, 32'h80000000, 32'hFFFFFF80, 2);
        run_load("lhu", 3'b101, 32'h102, 32'h80000000, 32'h00008000, 1);
        run_load("lh",  3'b001, 32'h102, 32'h80000000, 32'hFFFF8000, 3);
        run_load("lw",  3'b010, 32'h100, 32'h80000000, 32'h80000000, 1);
        run_load("lbu", 3'b100, 32'h101, 32'h0000A500, 32'h000000A5, 2);
        run_load("lb0", 3'b000, 32'h200, 32'h1234567F, 32'h0000007F, 1);
    endtask

    task automatic test_reset_mid();
        Done_I = 1'b1; MCR_I = 6'b01_0000; ASR_I = 32'h300; RAR_I = 5'd3; F3R_I = 3'b010;
        Mem_Req_Ready = 1'b1;
        tick();
        tick();
        Mem_Req_Ready = 1'b0;
        #1;
        n_vec++;
        if (Read_data_Ready !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_rdw: rdy=%b want 1", Read_data_Ready);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (Read_data_Ready !== 1'b0 || Feedback_Mem_Acc !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_force: rdy=%b fb=%b, want 0 0", Read_data_Ready,
                     Feedback_Mem_Acc);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        Read_data = 32'hFFFFFFFF; Read_data_Valid = 1'b1;
        #1;
        n_vec++;
        if (Done_O !== 1'b0 || Read_data_Ready !== 1'b0 || Feedback_Mem_Acc !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_idle: done=%b rdy=%b fb=%b, want 0 0 0", Done_O,
                     Read_data_Ready, Feedback_Mem_Acc);
        end
        tick();
        n_vec++;
        if (Done_O !== 1'b0 || RF_wdata_O !== 32'h0 || MemRead !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_late_valid: done=%b wd=%h rd=%b, want 0 0 0", Done_O,
                     RF_wdata_O, MemRead);
        end
        idle_inputs();
        tick();
    endtask

`ifdef MEM_PERF_CNT_EN
    task automatic test_perf_cnt();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_store(9);
        n_vec++;
        if (Mem_stall_cycles !== 32'd10) begin
            n_err++;
            $display("FAIL perf_cnt: got %0d want 10", Mem_stall_cycles);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (Mem_stall_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL perf_cnt_rst: got %0d want 0", Mem_stall_cycles);
        end
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_nonmem();
        test_back_to_back();
        test_store();
        test_loads();
        test_reset_mid();
`ifdef MEM_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
